// File: rtl/register_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : register_writeback_unit
// Description : Register-file write-port arbiter. Single-cycle ex results take
//               priority; multi-cycle results are buffered in a small FIFO and
//               drained when the port is free. A 32-bit pending scoreboard
//               tracks multi-cycle destinations still in flight so decode can
//               stall on RAW hazards.
// Revision    : 1.0 - initial release
// ============================================================================
module register_writeback_unit #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ex_valid,
    input  logic [4:0]               ex_rd,
    input  logic [XLEN-1:0]          ex_data,
    input  logic                     mc_valid,
    output logic                     mc_ready,
    input  logic [4:0]               mc_rd,
    input  logic [XLEN-1:0]          mc_data,
    input  logic                     issue_valid,
    input  logic [4:0]               issue_rd,
    input  logic [4:0]               chk_rs1,
    input  logic [4:0]               chk_rs2,
    output logic                     hazard,
    output logic                     RegWrite,
    output logic [4:0]               rd,
    output logic [XLEN-1:0]          Write_Data,
    output logic [31:0]              pending,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int              PW      = $clog2(DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [CW-1:0]   C_DEPTH = CW'(DEPTH);

    // FIFO storage and bookkeeping
    logic [4:0]       r_mem_rd   [DEPTH];
    logic [XLEN-1:0]  r_mem_data [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    // Scoreboard and write-port output register
    logic [31:0]      r_pending;
    logic             r_we;
    logic [4:0]       r_rd;
    logic [XLEN-1:0]  r_wdata;

    logic             w_ex_win;
    logic             w_pop;
    logic             w_push;
    logic             w_ready;
    logic [4:0]       w_head_rd;
    logic [XLEN-1:0]  w_head_data;
    logic [31:0]      w_set;
    logic [31:0]      w_clr;
    logic [31:0]      w_pend_nxt;

    // ex to x0 is dropped and must not steal the port from the FIFO
    assign w_ex_win    = ex_valid && (ex_rd != 5'd0);
    assign w_pop       = !w_ex_win && (r_count != '0);
    // No pop-through credit: a full FIFO refuses even while it is draining
    assign w_ready     = reset && (r_count < C_DEPTH);
    // A handshake to x0 completes but is discarded
    assign w_push      = mc_valid && w_ready && (mc_rd != 5'd0);
    assign w_head_rd   = r_mem_rd[r_rptr];
    assign w_head_data = r_mem_data[r_rptr];

    // Scoreboard next state: pop clears the head destination, issue sets; set wins
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (issue_valid && (issue_rd != 5'd0)) begin
            w_set[issue_rd] = 1'b1;
        end
        if (w_pop) begin
            w_clr[w_head_rd] = 1'b1;
        end
        w_pend_nxt = ((r_pending & ~w_clr) | w_set) & ~32'd1;
    end

    // FIFO payload storage; contents are only meaningful behind the pointers
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_wptr]   <= mc_rd;
            r_mem_data[r_wptr] <= mc_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally modulo DEPTH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Pending-destination scoreboard register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pend_nxt;
        end
    end

    // Write-port register: address/data hold when no write is granted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we    <= 1'b0;
            r_rd    <= '0;
            r_wdata <= '0;
        end else if (w_ex_win) begin
            r_we    <= 1'b1;
            r_rd    <= ex_rd;
            r_wdata <= ex_data;
        end else if (w_pop) begin
            r_we    <= 1'b1;
            r_rd    <= w_head_rd;
            r_wdata <= w_head_data;
        end else begin
            r_we    <= 1'b0;
        end
    end

    assign mc_ready   = w_ready;
    assign hazard     = r_pending[chk_rs1] | r_pending[chk_rs2];
    assign RegWrite   = r_we;
    assign rd         = r_rd;
    assign Write_Data = r_wdata;
    assign pending    = r_pending;
    assign count      = r_count;

endmodule
`default_nettype wire

// File: doc/register_writeback_unit.md
# register_writeback_unit

Writer side of the register file. Merges single-cycle ALU results and buffered multi-cycle results (loads, multiply) onto the register file's single write port (`RegWrite`, `rd`, `Write_Data`). Keeps a 32-bit pending-destination scoreboard so the decode stage can stall on RAW hazards against multi-cycle results still in flight. Sits between the EX/MEM back end and the register file.

## Interface

**Parameters**
- `XLEN`, 64: data width.
- `DEPTH`, 4: multi-cycle result FIFO entries; a power of 2, at least 2.

**Ports**
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `ex_valid`  in  1  single-cycle result present this cycle; never back-pressured.
- `ex_rd`  in  5  destination of the ex result.
- `ex_data`  in  XLEN  ex result value.
- `mc_valid`  in  1  multi-cycle result offered.
- `mc_ready`  out  1  unit accepts an mc result this cycle.
- `mc_rd`  in  5  destination of the mc result.
- `mc_data`  in  XLEN  mc result value.
- `issue_valid`  in  1  a multi-cycle instruction issues this cycle.
- `issue_rd`  in  5  destination of the issuing instruction.
- `chk_rs1`, `chk_rs2`  in  5 each  decode-stage source registers.
- `hazard`  out  1  either source register is pending.
- `RegWrite`  out  1  register file write enable (registered).
- `rd`  out  5  register file write address (registered).
- `Write_Data`  out  XLEN  register file write data (registered).
- `pending`  out  32  scoreboard bitmap; bit 0 is always 0.
- `count`  out  log2(DEPTH)+1  FIFO occupancy.

## Operation

**Write-port arbitration, per cycle**
- If `ex_valid=1` and `ex_rd≠0`: the ex result wins the port.
- Otherwise, if `count>0`: the FIFO head pops and takes the port.
- Otherwise: the port is idle.
- When the ex result wins, the FIFO does not pop. The ex path has absolute priority, so the FIFO can starve.
- A result with `ex_valid=1` and `ex_rd=0` is dropped. It does not block the FIFO.

**Output register**
- `RegWrite`, `rd` and `Write_Data` are loaded every edge from the granted source.
- When no write is granted, `RegWrite` goes to 0. `rd` and `Write_Data` hold their previous values.

**FIFO**
- `mc_ready = reset & (count<DEPTH)`. There is no pop-through credit: when the FIFO is full, `mc_ready` stays 0 even in a cycle that pops.
- A handshake (`mc_valid & mc_ready`) with `mc_rd≠0` pushes {`mc_rd`, `mc_data`}.
- A handshake with `mc_rd=0` completes and is discarded, with no push.
- Push and pop in the same cycle: `count` is unchanged.
- Read and write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.

**Scoreboard**
- On `issue_valid=1` and `issue_rd≠0`: `pending[issue_rd]` is set at the edge.
- A FIFO pop clears `pending[head.rd]` at the edge.
- Set and clear of the same bit in one cycle: set wins.
- Issuing to an already-pending register leaves the bit at 1, and the first pop clears it. Upstream must stall on `hazard` to avoid WAW; the unit does not count outstanding writes.
- ex results never touch `pending`.
- `hazard = pending[chk_rs1] | pending[chk_rs2]`, combinational. Index 0 always reads 0.

## Timing

**Reset**
- `reset=0` clears the following immediately (asynchronously): `RegWrite=0`, `rd=0`, `Write_Data=0`, `pending=0`, `count=0`, FIFO pointers, `mc_ready=0`, `hazard=0`.
- A reset mid-operation discards all queued results; no partial write escapes.
- `mc_ready` rises combinationally once `reset=1`.

**Latency**
- ex path: `ex_valid` sampled at edge N gives `RegWrite=1` from edge N until edge N+1. The register file commits it at edge N+1.
- mc path into an empty FIFO with no ex traffic: push at edge N, pop at edge N+1 (`RegWrite` high after N+1), committed at edge N+2. There is no bypass around the FIFO.
- Scoreboard: `pending` and `hazard` reflect a pop in the cycle after the popping edge, which is the same cycle `RegWrite` is high for that entry.
- One write per cycle at most. Sustained mc throughput is 1/cycle when there is no ex traffic.

## Test plan

1. **Reset then ex write.**
   - Stimulus: release reset; `ex_valid=1`, `ex_rd=5`, `ex_data=0xAA` for one cycle.
   - Required: next cycle `RegWrite=1`, `rd=5`, `Write_Data=0xAA`; the following cycle `RegWrite=0`. `ex_rd=0` produces no write.
2. **Scoreboard lifecycle.**
   - Stimulus: issue `rd=7`; `chk_rs1=7`; later push mc {7, 0x1234}.
   - Required: `hazard=1` from the cycle after issue until the cycle after the pop. The write {7, 0x1234} appears 2 cycles after the push.
3. **Starvation and ordering.**
   - Stimulus: push mc {1,0x11}, {2,0x22}, {3,0x33} while `ex_valid=1` for 3 cycles, then drop `ex_valid`.
   - Required: 3 ex writes, then mc writes in order 1, 2, 3 on consecutive cycles.
4. **Full FIFO.**
   - Stimulus: push DEPTH=4 entries under ex starvation.
   - Required: `count=4`, `mc_ready=0` even in the first popping cycle; it returns to 1 when `count=3`. Pointers wrap and the 5th entry is written correctly.
5. **Simultaneous set and clear.**
   - Stimulus: issue `rd=9` in the same cycle the FIFO head with rd 9 pops.
   - Required: `pending[9]` stays 1.
6. **Reset mid-stream.**
   - Stimulus: with `count=3` and `RegWrite=1`, pulse `reset` low for half a cycle.
   - Required: `RegWrite`, `count` and `pending` go to 0 immediately; no queued entry is written after release.
